shift_reg_load_arbiter: RTL and testbench

//  Shares one WIDTH-bit serial-in shift register between two requesters.

---
 rtl/shift_reg_load_arbiter.sv | 97 +++++++++
 tb/tb_shift_reg_load_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shift_reg_load_arbiter.sv
`default_nettype none
// shift_reg_load_arbiter: round-robin arbiter that serialises a requester word into
// an external serial-in shift register (MSB first), then verifies the readback. Rev 1.0
module shift_reg_load_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             err,
  output logic             busy,
  output logic             sr_entrada,
  output logic             sr_enable,
  input  logic [WIDTH-1:0] sr_saida
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic             mism_q, mism_d;
  logic             gnt_w;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign gnt_w = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    grant_d = grant_q;
    last_d  = last_q;
    mism_d  = mism_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = gnt_w;
          last_d  = gnt_w;
          word_d  = gnt_w ? data1 : data0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        mism_d  = (sr_saida != word_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mism_q  <= mism_d;
    end
  end

  // Outputs depend only on registered state, never on req*/data*.
  assign busy       = (state_q != S_IDLE);
  assign sr_enable  = (state_q == S_SHIFT);
  assign sr_entrada = sr_enable & word_q[cnt_q];
  assign ack0       = (state_q == S_DONE) & ~grant_q;
  assign ack1       = (state_q == S_DONE) &  grant_q;
  assign err        = (state_q == S_DONE) &  mism_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_load_arbiter.sv
`default_nettype none
// tb_shift_reg_load_arbiter: directed bench with a behavioural shift register model.
module tb_shift_reg_load_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       ack0, ack1, err, busy, sr_entrada, sr_enable;
  logic [3:0] sr_saida;
  logic [3:0] sr_q;
  logic       force_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_reg_load_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .err(err), .busy(busy),
    .sr_entrada(sr_entrada), .sr_enable(sr_enable), .sr_saida(sr_saida)
  );

  always @(posedge clk) if (sr_enable) sr_q <= {sr_q[2:0], sr_entrada};
  assign sr_saida = force_zero ? 4'h0 : sr_q;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_en", sr_enable, 0);
    check("rst_bit", sr_entrada, 0);
    check("rst_acks", {ack0, ack1, err}, 0);
    rst = 1'b0;
  endtask

  // Entered in the first SHIFT cycle; returns in the IDLE cycle after DONE.
  task automatic run_xfer(input int g, input logic [3:0] w, input bit corrupt, input bit mutate);
    for (int i = 3; i >= 0; i--) begin
      check("shift_busy", busy, 1);
      check("shift_en", sr_enable, 1);
      check("shift_bit", sr_entrada, w[i]);
      check("shift_acks", {ack0, ack1, err}, 0);
      if (i == 3 && mutate) begin data0 = 4'h5; req0 = 1'b0; end
      if (i == 0 && corrupt) force_zero = 1'b1;
      tick();
    end
    check("chk_en", sr_enable, 0);
    check("chk_bit", sr_entrada, 0);
    check("chk_busy", busy, 1);
    check("chk_acks", {ack0, ack1}, 0);
    if (!corrupt) check("chk_readback", sr_saida, w);
    tick();
    force_zero = 1'b0;
    check("done_ack0", ack0, (g == 0));
    check("done_ack1", ack1, (g == 1));
    check("done_err", err, corrupt);
    check("done_busy", busy, 1);
    check("done_en", sr_enable, 0);
    tick();
    check("idle_acks", {ack0, ack1, err}, 0);
    check("idle_busy", busy, 0);
    check("idle_en", sr_enable, 0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 4'h0; data1 = 4'h0;
    force_zero = 1'b0; sr_q = 4'h0;
    #2;
    do_reset();

    // Single requester, word 1011
    req0 = 1'b1; data0 = 4'b1011;
    tick();
    run_xfer(0, 4'hB, 1'b0, 1'b0);
    req0 = 1'b0;
    tick();
    check("t1_stay_idle", busy, 0);

    // Both requesting: 0, 1, 0
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'hC;
    tick();
    run_xfer(0, 4'h3, 1'b0, 1'b0);
    tick();
    run_xfer(1, 4'hC, 1'b0, 1'b0);
    tick();
    run_xfer(0, 4'h3, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Readback mismatch, then clean transfer
    req1 = 1'b1; data1 = 4'h9;
    tick();
    run_xfer(1, 4'h9, 1'b1, 1'b0);
    tick();
    run_xfer(1, 4'h9, 1'b0, 1'b0);
    req1 = 1'b0;
    tick();

    // Inputs changed and req dropped mid-transfer
    req0 = 1'b1; data0 = 4'hA;
    tick();
    run_xfer(0, 4'hA, 1'b0, 1'b1);
    tick();
    check("t4_no_regrant", busy, 0);

    // Async reset during the second SHIFT cycle
    req1 = 1'b1; data1 = 4'h6;
    tick();
    check("t5_shift1", sr_enable, 1);
    tick();
    check("t5_shift2", sr_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_en", sr_enable, 0);
    check("t5_async_bit", sr_entrada, 0);
    check("t5_async_acks", {ack0, ack1, err}, 0);
    tick();
    rst = 1'b0;
    check("t5_post_acks", {ack0, ack1}, 0);
    tick();
    run_xfer(1, 4'h6, 1'b0, 1'b0);
    req1 = 1'b0;
    tick();

    // Held req1: back-to-back with one IDLE cycle
    req1 = 1'b1; data1 = 4'hD;
    tick();
    run_xfer(1, 4'hD, 1'b0, 1'b0);
    tick();
    run_xfer(1, 4'hD, 1'b0, 1'b0);
    req1 = 1'b0;
    tick();
    check("t6_final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
